// File: rtl/data_mem_pkg.sv
// Shared encodings for the handshaked data memory: access sizes, FSM states
// and the wait-state bound.
package data_mem_pkg;

  localparam logic [1:0] SZ_WORD    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_BYTE    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  // The wait counter is 3 bits wide, so 7 is the deepest legal setting.
  localparam int unsigned WAIT_STATES_MAX = 7;
  localparam int unsigned WS_CNT_W        = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // A request is rejected when its size code is reserved or when the address
  // is not naturally aligned for the access width.
  function automatic logic req_is_illegal(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_WORD: bad = (addr_lo != 2'b00);
      SZ_HALF: bad = addr_lo[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Assembles a load result from four little-endian bytes (b0 = byte at the
// access address) and applies sign or zero extension for half/byte loads.
module load_extend
  import data_mem_pkg::*;
(
  input  logic [7:0]  i_b0,
  input  logic [7:0]  i_b1,
  input  logic [7:0]  i_b2,
  input  logic [7:0]  i_b3,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  // Select lanes by size; word loads ignore the signed flag.
  always_comb begin
    o_data = '0;
    case (i_size)
      SZ_WORD: o_data = {i_b3, i_b2, i_b1, i_b0};
      SZ_HALF: o_data = {{16{i_signed & i_b1[7]}}, i_b1, i_b0};
      SZ_BYTE: o_data = {{24{i_signed & i_b0[7]}}, i_b0};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_hs.sv
// Byte-addressable 32-bit data memory with valid/ready request and response
// channels, word/half/byte accesses, programmable wait states and an error
// response for misaligned or reserved-size requests.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; accepts on any edge with req_valid=1
// WAIT  | legal request latched, counting down the wait states
// RESP  | response held on rsp_* until the consumer asserts rsp_ready
module data_mem_hs
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned         DEPTH    = 2**ADDR_W;
  localparam logic [WS_CNT_W-1:0] WS_LOAD  = WS_CNT_W'(WAIT_STATES);
  localparam bit                  HAS_WAIT = (WAIT_STATES != 0);

  if (WAIT_STATES > WAIT_STATES_MAX) begin : g_ws_check
    $error("data_mem_hs: WAIT_STATES must be in 0..7");
  end

  state_t              r_state;
  state_t              w_next_state;
  logic [WS_CNT_W-1:0] r_cnt;

  logic                r_we;
  logic [1:0]          r_size;
  logic                r_signed;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;

  logic [31:0]         r_rsp_rdata;
  logic                r_rsp_err;

  logic [7:0]          r_mem [DEPTH];

  logic                w_accept;
  logic                w_req_err;
  logic                w_acc_fire;
  logic                w_acc_we;
  logic [1:0]          w_acc_size;
  logic                w_acc_signed;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [31:0]         w_acc_wdata;
  logic [ADDR_W-1:0]   w_lane_addr [4];
  logic [7:0]          w_rbyte [4];
  logic [3:0]          w_lane_en;
  logic [31:0]         w_ext;

  // Acceptance, error classification and the single edge on which the access
  // happens: the accept edge itself with no wait states, otherwise the edge
  // where the wait counter reaches 1.
  always_comb begin
    w_accept   = (r_state == IDLE) && req_valid;
    w_req_err  = req_is_illegal(req_size, req_addr[1:0]);
    w_acc_fire = (w_accept && !w_req_err && !HAS_WAIT) ||
                 ((r_state == WAIT) && (r_cnt == WS_CNT_W'(1)));
  end

  // Access operands come straight from the request port when the access
  // happens on the accept edge, otherwise from the latched request.
  always_comb begin
    if (r_state == IDLE) begin
      w_acc_we     = req_we;
      w_acc_size   = req_size;
      w_acc_signed = req_signed;
      w_acc_addr   = req_addr;
      w_acc_wdata  = req_wdata;
    end else begin
      w_acc_we     = r_we;
      w_acc_size   = r_size;
      w_acc_signed = r_signed;
      w_acc_addr   = r_addr;
      w_acc_wdata  = r_wdata;
    end
  end

  // Byte lane addresses and enables. Aligned accesses never run past the top
  // of memory, so the natural wrap of the adder is never exercised on lanes
  // that are actually enabled.
  always_comb begin
    w_lane_en = 4'b0000;
    case (w_acc_size)
      SZ_WORD: w_lane_en = 4'b1111;
      SZ_HALF: w_lane_en = 4'b0011;
      SZ_BYTE: w_lane_en = 4'b0001;
      default: w_lane_en = 4'b0000;
    endcase
    for (int i = 0; i < 4; i++) begin
      w_lane_addr[i] = w_acc_addr + ADDR_W'(i);
      w_rbyte[i]     = r_mem[w_lane_addr[i]];
    end
  end

  load_extend u_load_extend (
    .i_b0     (w_rbyte[0]),
    .i_b1     (w_rbyte[1]),
    .i_b2     (w_rbyte[2]),
    .i_b3     (w_rbyte[3]),
    .i_size   (w_acc_size),
    .i_signed (w_acc_signed),
    .o_data   (w_ext)
  );

  // Byte array write; storage is deliberately not touched by reset.
  always_ff @(posedge clk) begin
    if (w_acc_fire && w_acc_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lane_en[i]) begin
          r_mem[w_lane_addr[i]] <= w_acc_wdata[8*i +: 8];
        end
      end
    end
  end

  // Latch every request field at acceptance for use during WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_size   <= SZ_WORD;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (w_accept) begin
      r_we     <= req_we;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
    end
  end

  // Wait-state down-counter: loaded on a legal accept, decremented in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      if (!w_req_err && HAS_WAIT) begin
        r_cnt <= WS_LOAD;
      end
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - WS_CNT_W'(1);
    end
  end

  // Response registers: set on error accept or on the access edge, held
  // through RESP and cleared by the response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept && w_req_err) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b1;
    end else if (w_acc_fire) begin
      r_rsp_rdata <= w_acc_we ? 32'h0 : w_ext;
      r_rsp_err   <= 1'b0;
    end else if ((r_state == RESP) && rsp_ready) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_req_err || !HAS_WAIT) begin
            w_next_state = RESP;
          end else begin
            w_next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == WS_CNT_W'(1)) begin
          w_next_state = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs, decoded from the current state only.
  always_comb begin
    req_ready = (r_state == IDLE);
    rsp_valid = (r_state == RESP);
    busy      = (r_state != IDLE);
    rsp_rdata = r_rsp_rdata;
    rsp_err   = r_rsp_err;
  end

endmodule

// File: tb/tb_data_mem_hs.sv
// Directed bench for data_mem_hs. Three instances share one clock:
// index 0 has WAIT_STATES=1, index 1 has 3, index 2 has 0.
module tb_data_mem_hs;
  import data_mem_pkg::*;

  logic             clk = 1'b0;
  logic [2:0]       rst_n;
  logic [2:0]       req_valid;
  logic [2:0]       req_ready;
  logic [2:0]       req_we;
  logic [2:0][1:0]  req_size;
  logic [2:0]       req_signed;
  logic [2:0][7:0]  req_addr;
  logic [2:0][31:0] req_wdata;
  logic [2:0]       rsp_valid;
  logic [2:0]       rsp_ready;
  logic [2:0][31:0] rsp_rdata;
  logic [2:0]       rsp_err;
  logic [2:0]       busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_mem_hs #(.ADDR_W(8), .WAIT_STATES(1)) dut_ws1 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .busy(busy[0]));

  data_mem_hs #(.ADDR_W(8), .WAIT_STATES(3)) dut_ws3 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .busy(busy[1]));

  data_mem_hs #(.ADDR_W(8), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_size(req_size[2]), .req_signed(req_signed[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]),
    .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]),
    .busy(busy[2]));

  typedef struct {
    int          k;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input int k, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    vec_t v;
    v.k = k; v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    vecs.push_back(v);
  endtask

  // One complete transaction with rsp_ready held high; latency counts cycles
  // after the accepting edge until rsp_valid is first seen.
  task automatic do_req(input int k, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, ".req_ready"}, 32'(req_ready[k]), 32'h1);
    req_we[k]     = we;
    req_size[k]   = size;
    req_signed[k] = sgn;
    req_addr[k]   = addr;
    req_wdata[k]  = wdata;
    req_valid[k]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0;
    lat = 1;
    while (!rsp_valid[k] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rdata"}, rsp_rdata[k], exp_rdata);
    chk({tag, ".err"}, 32'(rsp_err[k]), 32'(exp_err));
    chk({tag, ".busy"}, 32'(busy[k]), 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".valid_clr"}, 32'(rsp_valid[k]), 32'h0);
    chk({tag, ".rdata_clr"}, rsp_rdata[k], 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n      = '0;
    req_valid  = '0;
    req_we     = '0;
    req_size   = '0;
    req_signed = '0;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = '1;

    // WAIT_STATES=1: store/load word, extensions, error paths, extra lanes.
    add_vec(0, 1, SZ_WORD, 0, 8'h10, 32'hDEADBEEF, 32'h00000000, 0, 2);
    add_vec(0, 0, SZ_WORD, 0, 8'h10, 32'h0,        32'hDEADBEEF, 0, 2);
    add_vec(0, 0, SZ_BYTE, 1, 8'h13, 32'h0,        32'hFFFFFFDE, 0, 2);
    add_vec(0, 0, SZ_BYTE, 0, 8'h13, 32'h0,        32'h000000DE, 0, 2);
    add_vec(0, 0, SZ_HALF, 1, 8'h12, 32'h0,        32'hFFFFDEAD, 0, 2);
    add_vec(0, 0, SZ_HALF, 0, 8'h12, 32'h0,        32'h0000DEAD, 0, 2);
    add_vec(0, 0, SZ_HALF, 1, 8'h10, 32'h0,        32'hFFFFBEEF, 0, 2);
    add_vec(0, 1, SZ_HALF, 0, 8'h11, 32'h00001234, 32'h00000000, 1, 1);
    add_vec(0, 0, SZ_WORD, 0, 8'h10, 32'h0,        32'hDEADBEEF, 0, 2);
    add_vec(0, 0, 2'b11,   0, 8'h00, 32'h0,        32'h00000000, 1, 1);
    add_vec(0, 0, SZ_WORD, 0, 8'h12, 32'h0,        32'h00000000, 1, 1);
    add_vec(0, 1, 2'b11,   0, 8'h10, 32'h55555555, 32'h00000000, 1, 1);
    add_vec(0, 1, SZ_BYTE, 0, 8'h11, 32'h000000AB, 32'h00000000, 0, 2);
    add_vec(0, 0, SZ_WORD, 1, 8'h10, 32'h0,        32'hDEADABEF, 0, 2);
    add_vec(0, 1, SZ_HALF, 1, 8'h12, 32'hFFFF7777, 32'h00000000, 0, 2);
    add_vec(0, 0, SZ_WORD, 0, 8'h10, 32'h0,        32'h7777ABEF, 0, 2);
    add_vec(0, 0, SZ_BYTE, 1, 8'h11, 32'h0,        32'hFFFFFFAB, 0, 2);
    add_vec(0, 0, SZ_HALF, 0, 8'h10, 32'h0,        32'h0000ABEF, 0, 2);
    // WAIT_STATES=3: preload before the reset-abort sequence.
    add_vec(1, 1, SZ_WORD, 0, 8'h20, 32'h11111111, 32'h00000000, 0, 4);
    // WAIT_STATES=0: top-of-memory byte, neighbour untouched.
    add_vec(2, 1, SZ_WORD, 0, 8'hFC, 32'h44332211, 32'h00000000, 0, 1);
    add_vec(2, 1, SZ_BYTE, 0, 8'hFF, 32'h00000080, 32'h00000000, 0, 1);
    add_vec(2, 0, SZ_BYTE, 1, 8'hFF, 32'h0,        32'hFFFFFF80, 0, 1);
    add_vec(2, 0, SZ_BYTE, 0, 8'hFF, 32'h0,        32'h00000080, 0, 1);
    add_vec(2, 0, SZ_BYTE, 0, 8'hFE, 32'h0,        32'h00000033, 0, 1);
    add_vec(2, 0, SZ_WORD, 0, 8'hFC, 32'h0,        32'h80332211, 0, 1);
    add_vec(2, 0, SZ_HALF, 1, 8'hFE, 32'h0,        32'hFFFF8033, 0, 1);

    // Reset values while reset is asserted.
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d.req_ready", k), 32'(req_ready[k]), 32'h1);
      chk($sformatf("rst%0d.rsp_valid", k), 32'(rsp_valid[k]), 32'h0);
      chk($sformatf("rst%0d.rsp_rdata", k), rsp_rdata[k], 32'h0);
      chk($sformatf("rst%0d.rsp_err", k), 32'(rsp_err[k]), 32'h0);
      chk($sformatf("rst%0d.busy", k), 32'(busy[k]), 32'h0);
    end
    rst_n = '1;

    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i].k, vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr,
             vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat,
             $sformatf("vec%0d", i));
    end

    // Backpressure on instance 0: response held, next request waits.
    @(negedge clk);
    rsp_ready[0]  = 1'b0;
    req_we[0]     = 1'b0;
    req_size[0]   = SZ_WORD;
    req_signed[0] = 1'b0;
    req_addr[0]   = 8'h10;
    req_valid[0]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp.c1_valid", 32'(rsp_valid[0]), 32'h0);
    req_size[0]   = SZ_BYTE;
    req_signed[0] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp.hold%0d.valid", i), 32'(rsp_valid[0]), 32'h1);
      chk($sformatf("bp.hold%0d.rdata", i), rsp_rdata[0], 32'h7777ABEF);
      chk($sformatf("bp.hold%0d.req_ready", i), 32'(req_ready[0]), 32'h0);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp.after_hs.valid", 32'(rsp_valid[0]), 32'h0);
    chk("bp.after_hs.rdata", rsp_rdata[0], 32'h0);
    chk("bp.after_hs.req_ready", 32'(req_ready[0]), 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("bp.next.c1_valid", 32'(rsp_valid[0]), 32'h0);
    @(negedge clk);
    chk("bp.next.c2_valid", 32'(rsp_valid[0]), 32'h1);
    chk("bp.next.rdata", rsp_rdata[0], 32'hFFFFFFEF);
    chk("bp.next.err", 32'(rsp_err[0]), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("bp.next.valid_clr", 32'(rsp_valid[0]), 32'h0);

    // Reset during WAIT on instance 1 drops the pending store.
    @(negedge clk);
    req_we[1]     = 1'b1;
    req_size[1]   = SZ_WORD;
    req_signed[1] = 1'b0;
    req_addr[1]   = 8'h20;
    req_wdata[1]  = 32'hCAFEF00D;
    req_valid[1]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("rstw.c1_busy", 32'(busy[1]), 32'h1);
    @(negedge clk);
    chk("rstw.c2_busy", 32'(busy[1]), 32'h1);
    rst_n[1] = 1'b0;
    #1;
    chk("rstw.rsp_valid", 32'(rsp_valid[1]), 32'h0);
    chk("rstw.busy", 32'(busy[1]), 32'h0);
    chk("rstw.req_ready", 32'(req_ready[1]), 32'h1);
    @(negedge clk);
    rst_n[1] = 1'b1;
    chk("rstw.rel_req_ready", 32'(req_ready[1]), 32'h1);
    chk("rstw.rel_rdata", rsp_rdata[1], 32'h0);
    do_req(1, 0, SZ_WORD, 0, 8'h20, 32'h0, 32'h11111111, 0, 4, "rstw.lw");
    do_req(1, 0, SZ_BYTE, 1, 8'h23, 32'h0, 32'h00000011, 0, 4, "rstw.lb");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_hs.md
Name: data_mem_hs

Overview:
Parametrised, byte-addressable 32-bit data memory with a valid/ready request channel and a valid/ready response channel. Supports word, half and byte loads/stores with sign/zero extension and a programmable number of wait states. Detects misaligned and illegal accesses and returns an error response. Sits between the core's load/store stage and storage, and supports a stalling pipeline.

Parameters:
ADDR_W, 8, byte-address width; memory holds 2**ADDR_W bytes.
WAIT_STATES, 1, extra cycles between request accept and the access; legal range 0..7.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  reset; asynchronous, active-low.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 word, 01 half, 10 byte, 11 illegal.
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
req_addr  in  ADDR_W  byte address.
req_wdata  in  32  store data; low bytes used for half/byte.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer takes the response.
rsp_rdata  out  32  load result; 0 for stores and errors.
rsp_err  out  1  misaligned or illegal request.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Storage is 2**ADDR_W bytes, little-endian (byte at addr is bits 7:0). Contents are not cleared by reset.
- Reset (rst_n low, asynchronous): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. A request is accepted on an edge where req_valid=1; that cycle is cycle 0. All request fields are latched at acceptance.
- Error check at acceptance. Any of the following is an error:
  - req_size=11;
  - word access with addr[1:0]!=0;
  - half access with addr[0]!=0.
- On error: go to RESP with rsp_err=1 and rsp_rdata=0. No memory write occurs. rsp_valid is first high in cycle 1, regardless of WAIT_STATES.
- Legal request, WAIT_STATES=0: the access happens on the accepting edge; go to RESP.
- Legal request, WAIT_STATES>0: load the counter with WAIT_STATES and go to WAIT. Decrement the counter each cycle. The access happens on the edge where the counter equals 1; go to RESP.
- Legal-request latency: rsp_valid is first high in cycle WAIT_STATES+1.
- Access, store: write 4, 2 or 1 bytes of req_wdata[31:0], [15:0] or [7:0] on a single edge. No other byte changes.
- Access, load: register the assembled and extended value into rsp_rdata.
  - Half: sign bit is bit 15.
  - Byte: sign bit is bit 7.
  - req_signed is ignored for word loads and for stores.
- Address wrap: aligned accesses never cross the top of memory, so no wrap logic is needed.
- RESP: rsp_valid=1, req_ready=0. rsp_rdata and rsp_err stay stable until the handshake.
  - On an edge with rsp_ready=1: go to IDLE, clear rsp_valid, rsp_rdata and rsp_err.
  - One bubble between consecutive requests: max throughput is one request per WAIT_STATES+2 cycles.
- req_valid outside IDLE is ignored (req_ready=0). The requester must hold the request stable until accepted.
- Only one request is outstanding at a time.
- Reset mid-operation: the pending request is dropped. A store still in WAIT is not performed. A response in RESP is lost.

Decomposition:
- Shared package data_mem_pkg holds:
  - size encodings SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10;
  - FSM state encoding IDLE/WAIT/RESP;
  - the WAIT_STATES legality bound (7).
- One sub-module, load_extend: combinational. Takes four raw bytes, size and signed flag; outputs the 32-bit extended value.
- The top holds the FSM, wait counter, request latches, byte array, and write lane logic.

Test Plan:
1. ADDR_W=8, WAIT_STATES=1. SW 0x10 = 0xDEADBEEF, then LW 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid first high in cycle 2 for both requests.
2. After test 1: LB signed 0x13 -> 0xFFFFFFDE. LBU 0x13 -> 0x000000DE. LH signed 0x12 -> 0xFFFFDEAD. LHU 0x12 -> 0x0000DEAD. LH signed 0x10 -> 0xFFFFBEEF.
3. Error paths:
   - SH 0x11 data 0x1234 -> rsp_err=1 in cycle 1, rsp_rdata=0; a following LW 0x10 still returns 0xDEADBEEF.
   - req_size=11 at 0x00 -> rsp_err=1.
   - LW 0x12 -> rsp_err=1.
4. Backpressure: LW 0x10 with rsp_ready low for 5 cycles -> rsp_valid=1 and rsp_rdata=0xDEADBEEF stable throughout, req_ready=0; a new req_valid is not accepted until one cycle after the rsp handshake.
5. WAIT_STATES=3. Write LW-visible value 0x11111111 at 0x20, then SW 0x20 = 0xCAFEF00D. Drive rst_n low in cycle 2 (state WAIT) -> immediate rsp_valid=0, busy=0. After release, req_ready=1 and LW 0x20 returns 0x11111111.
6. WAIT_STATES=0. SB 0xFF data 0x00000080, then LB signed 0xFF -> 0xFFFFFF80, LBU -> 0x00000080. Latency: rsp_valid first high in cycle 1. Neighbouring byte 0xFE is unchanged.
